// File: rtl/dmem_512x32_ctrl_pkg.sv
// dmem_512x32_ctrl_pkg: shared constants, size encodings and response-state type for the data memory
package dmem_512x32_ctrl_pkg;
  localparam int WORD_AW = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH = 2 ** WORD_AW;
  localparam int LANES = DATA_W / 8;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/dmem_dec_9to512.sv
// dmem_dec_9to512: one-hot word-line decoder, all lines low when disabled
module dmem_dec_9to512
  import dmem_512x32_ctrl_pkg::*;
(
  input  logic               en,
  input  logic [WORD_AW-1:0] addr,
  output logic [DEPTH-1:0]   sel
);
  assign sel = en ? DEPTH'(1) << addr : '0;
endmodule

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: access check, store lane enables/replication and load extract/extend
module dmem_lane_fmt
  import dmem_512x32_ctrl_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic              err,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wrep,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] sh;
  always_comb begin
    sh = rword >> {off, 3'b000};
    err = size == 2'b11 | (size == SZ_HALF & off[0]) | (size == SZ_WORD & off != 2'b00);
    be = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata = size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
            size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : rword;
  end
endmodule

// File: rtl/dmem_512x32_ctrl.sv
// dmem_512x32_ctrl: 512x32 MEM-stage data memory with sub-word access and registered valid/ready response
module dmem_512x32_ctrl
  import dmem_512x32_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [10:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  state_t state, nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] sel;
  logic acc, err;
  logic [LANES-1:0] be;
  logic [DATA_W-1:0] wrep, ld;
  assign rsp_valid = state == FULL;
  assign req_ready = !rsp_valid | rsp_ready;
  assign acc = req_valid & req_ready;
  dmem_dec_9to512 u_dec (
    .en(acc),
    .addr(req_addr[10:2]),
    .sel(sel)
  );
  dmem_lane_fmt u_fmt (
    .size(req_size),
    .uns(req_unsigned),
    .off(req_addr[1:0]),
    .wdata(req_wdata),
    .rword(mem[req_addr[10:2]]),
    .err(err),
    .be(be),
    .wrep(wrep),
    .rdata(ld)
  );
  always_comb begin
    nxt = acc ? FULL : rsp_ready ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    state <= !rst_n ? EMPTY : nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else if (acc) begin
      rsp_rdata <= (err | req_we) ? '0 : ld;
      rsp_err <= err;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && req_we && !err)
      for (int w = 0; w < DEPTH; w++)
        for (int l = 0; l < LANES; l++)
          if (sel[w] && be[l]) mem[w][8*l +: 8] <= wrep[8*l +: 8];
  end
endmodule

// File: tb/tb_dmem_512x32_ctrl.sv
// tb_dmem_512x32_ctrl: directed and randomized checks of the data memory against a byte-mask reference model
module tb_dmem_512x32_ctrl;
  logic clk = 0, rst_n = 0, req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic rsp_valid, rsp_ready = 1, rsp_err;
  logic [1:0] req_size = 0;
  logic [10:0] req_addr = 0;
  logic [31:0] req_wdata = 0, rsp_rdata;
  logic [31:0] rmem [512];
  logic pend = 0, perr = 0;
  logic [31:0] pexp = 0, hold;
  string ptag = "";
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_512x32_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [10:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic er);
    int w = int'(a) / 4;
    int o = int'(a) % 4;
    int nb = 8 << sz;
    logic [31:0] mask, v;
    er = (sz == 3) || (sz == 1 && o % 2 != 0) || (sz == 2 && o != 0);
    rd = 0;
    if (er) return;
    mask = (nb == 32) ? 32'hFFFF_FFFF : (32'h1 << nb) - 1;
    if (we) rmem[w] = (rmem[w] & ~(mask << (8 * o))) | ((d & mask) << (8 * o));
    else begin
      v = (rmem[w] >> (8 * o)) & mask;
      if (!uns && v[nb-1]) v = v | ~mask;
      rd = v;
    end
  endfunction
  task automatic step(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [10:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    if (pend) chk(ptag, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, perr, pexp});
    else chk("idle", {33'b0, rsp_valid}, 34'b0);
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    rsp_ready = 1;
    if (v) model(we, sz, uns, a, d, pexp, perr);
    pend = v;
    ptag = tag;
  endtask
  initial begin
    req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 0; req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'b0);
    chk("reset_ready", {33'b0, req_ready}, 34'b1);
    req_valid = 0;
    rst_n = 1;
    for (int i = 0; i < 512; i++) step(1, 1, 2'b10, 0, 11'(i * 4), i, "stream_st");
    for (int i = 0; i < 512; i++) step(1, 0, 2'b10, 0, 11'(i * 4), 0, "stream_ld");
    step(1, 1, 2'b10, 0, 11'h004, 32'hDEAD_BEEF, "st_word");
    step(1, 0, 2'b10, 0, 11'h004, 0, "ld_word");
    step(1, 1, 2'b10, 0, 11'h100, 32'h1122_3344, "preload");
    step(1, 1, 2'b00, 0, 11'h101, 32'h0000_0080, "st_byte");
    step(1, 0, 2'b10, 0, 11'h100, 0, "ld_after_byte");
    step(1, 0, 2'b00, 0, 11'h101, 0, "ld_byte_s");
    step(1, 0, 2'b00, 1, 11'h101, 0, "ld_byte_u");
    step(1, 1, 2'b01, 0, 11'h1FE, 32'h0000_BEEF, "st_half");
    step(1, 0, 2'b01, 0, 11'h1FE, 0, "ld_half_s");
    step(1, 0, 2'b01, 1, 11'h1FE, 0, "ld_half_u");
    step(1, 0, 2'b10, 0, 11'h1FC, 0, "ld_half_word");
    step(1, 0, 2'b10, 0, 11'h002, 0, "err_ld_mis");
    step(1, 1, 2'b10, 0, 11'h003, 32'hFFFF_FFFF, "err_st_mis");
    step(1, 0, 2'b10, 0, 11'h000, 0, "after_err_st");
    step(1, 0, 2'b11, 0, 11'h010, 0, "err_size");
    step(1, 1, 2'b01, 0, 11'h105, 32'h1234, "err_half_mis");
    step(1, 0, 2'b10, 0, 11'h104, 0, "after_err_half");
    step(1, 0, 2'b10, 0, 11'h100, 0, "bp_load");
    @(negedge clk);
    chk("bp_first", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, perr, pexp});
    hold = pexp;
    rsp_ready = 0;
    req_valid = 1; req_we = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 11'h004;
    #1 chk("bp_ready0", {33'b0, req_ready}, 34'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, hold});
      chk("bp_ready0", {33'b0, req_ready}, 34'b0);
    end
    @(negedge clk);
    chk("bp_release_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, hold});
    rsp_ready = 1;
    #1 chk("bp_ready1", {33'b0, req_ready}, 34'b1);
    model(0, 2'b10, 0, 11'h004, 0, pexp, perr);
    pend = 1;
    ptag = "bp_next";
    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      logic [10:0] a;
      sz = 2'($urandom_range(0, 3));
      a = 11'($urandom);
      if ($urandom_range(0, 3) != 0) a = (sz == 2) ? a & ~11'h3 : (sz == 1) ? a & ~11'h1 : a;
      step(1, 1'($urandom), sz, 1'($urandom), a, $urandom, "random");
    end
    step(1, 1, 2'b10, 0, 11'h014, 32'h1234_5678, "pre_rst");
    @(negedge clk);
    chk("pre_rst", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, perr, pexp});
    rst_n = 0; rsp_ready = 0;
    req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 11'h014; req_wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    chk("rst_discard", {rsp_valid, rsp_err, rsp_rdata}, 34'b0);
    rst_n = 1; req_valid = 0; rsp_ready = 1;
    pend = 0;
    step(1, 0, 2'b10, 0, 11'h014, 0, "rst_no_write");
    step(0, 0, 2'b10, 0, 0, 0, "flush");
    step(0, 0, 2'b10, 0, 0, 0, "idle");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
